muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_step.sv | 33 +++
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, step count.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_RSV6  = 3'b110,
    OP_RSV7  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2
  } state_e;

  localparam int MULDIV_STEPS = 32;

  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: restoring subtract-or-keep (divide) or
// conditional add then right shift (multiply) over an {acc, sh} pair.
module muldiv_step (
  input  logic        is_div,
  input  logic [31:0] acc,
  input  logic [31:0] sh,
  input  logic [31:0] m,
  output logic [31:0] acc_n,
  output logic [31:0] sh_n
);

  logic [32:0] shifted;
  logic        ge;
  logic [31:0] diff;
  logic [32:0] sum;

  always_comb begin
    // Divide: partial remainder picks up the next dividend bit from sh's MSB.
    shifted = {acc, sh[31]};
    ge      = shifted >= {1'b0, m};
    diff    = shifted[31:0] - m;
    // Multiply: product high half accumulates, low half shifts in from the right.
    sum     = {1'b0, acc} + (sh[0] ? {1'b0, m} : 33'd0);
    if (is_div) begin
      acc_n = ge ? diff : shifted[31:0];
      sh_n  = {sh[30:0], ge};
    end else begin
      acc_n = sum[32:1];
      sh_n  = {sum[0], sh[31:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit.
// Define MULDIV_FAST_MUL_EN for single-edge multiply instead of the 32-step path.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  dbg_state
);

  // Handshake: start is a single-cycle request, taken only when busy=0 and
  // flush=0; done is a one-cycle pulse and is never back-pressured.

  state_e      state, state_n;
  logic [5:0]  cnt;
  logic [31:0] acc, sh, mval;
  logic        is_div, neg_q, neg_r;
  logic [31:0] step_acc, step_sh;
  op_e         op_c;
  logic        signed_op, accept;
  logic [31:0] a_mag, b_mag;

  assign op_c      = op_e'(op);
  assign signed_op = (op_c == OP_MULT) || (op_c == OP_DIV);
  assign a_mag     = signed_op ? abs32(a) : a;
  assign b_mag     = signed_op ? abs32(b) : b;
  assign accept    = (state == ST_IDLE) && start && !flush;
  assign busy      = (state == ST_CALC) || (state == ST_FIXUP);
  assign dbg_state = state;

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] a_ext, b_ext, fast_prod;
  always_comb begin
    // Low 64 bits of the extended product are right for signed and unsigned.
    a_ext     = {{32{signed_op & a[31]}}, a};
    b_ext     = {{32{signed_op & b[31]}}, b};
    fast_prod = a_ext * b_ext;
  end
`endif

  muldiv_step u_step (
    .is_div (is_div),
    .acc    (acc),
    .sh     (sh),
    .m      (mval),
    .acc_n  (step_acc),
    .sh_n   (step_sh)
  );

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (op_c)
`ifdef MULDIV_FAST_MUL_EN
            OP_MULT, OP_MULTU: state_n = ST_IDLE;
`else
            OP_MULT, OP_MULTU: state_n = ST_CALC;
`endif
            OP_DIV, OP_DIVU:   state_n = (b == 32'd0) ? ST_IDLE : ST_CALC;
            default:           state_n = ST_IDLE;
          endcase
        end
      end
      ST_CALC:  if (cnt == 6'(MULDIV_STEPS - 1)) state_n = ST_FIXUP;
      ST_FIXUP: state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
    if (flush) state_n = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= 6'd0;
      acc         <= 32'd0;
      sh          <= 32'd0;
      mval        <= 32'd0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      hi          <= 32'd0;
      lo          <= 32'd0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      if (flush) begin
        cnt <= 6'd0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              case (op_c)
                OP_MTHI: hi <= a;
                OP_MTLO: lo <= a;
                OP_DIV, OP_DIVU: begin
                  if (b == 32'd0) begin
                    done        <= 1'b1;
                    div_by_zero <= 1'b1;
                  end else begin
                    acc    <= 32'd0;
                    sh     <= a_mag;
                    mval   <= b_mag;
                    is_div <= 1'b1;
                    neg_q  <= signed_op & (a[31] ^ b[31]);
                    neg_r  <= signed_op & a[31];
                    cnt    <= 6'd0;
                  end
                end
                OP_MULT, OP_MULTU: begin
`ifdef MULDIV_FAST_MUL_EN
                  {hi, lo} <= fast_prod;
                  done     <= 1'b1;
`else
                  acc    <= 32'd0;
                  sh     <= a_mag;
                  mval   <= b_mag;
                  is_div <= 1'b0;
                  neg_q  <= signed_op & (a[31] ^ b[31]);
                  neg_r  <= 1'b0;
                  cnt    <= 6'd0;
`endif
                end
                default: ;
              endcase
            end
          end
          ST_CALC: begin
            acc <= step_acc;
            sh  <= step_sh;
            cnt <= cnt + 6'd1;
          end
          ST_FIXUP: begin
            // Divide leaves quotient in sh, remainder in acc; multiply leaves {acc, sh}.
            if (is_div) begin
              lo <= neg_q ? (~sh + 32'd1) : sh;
              hi <= neg_r ? (~acc + 32'd1) : acc;
            end else begin
              {hi, lo} <= neg_q ? (~{acc, sh} + 64'd1) : {acc, sh};
            end
            done <= 1'b1;
            cnt  <= 6'd0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops
// against an arithmetic reference model of HI/LO.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic [64:0] exp_q[$];

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
  localparam int MUL_BUSY = 0;
`else
  localparam int MUL_LAT = 34;
  localparam int MUL_BUSY = 33;
`endif

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result {dbz, hi, lo} from plain arithmetic.
  function automatic logic [64:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: begin p = 64'(sx * sy); return {1'b0, p}; end
      3'd1: begin p = {32'd0, x} * {32'd0, y}; return {1'b0, p}; end
      3'd2: begin
        if (y == 0) return {1'b1, m_hi, m_lo};
        q = sx / sy; r = sx % sy;
        return {1'b0, 32'(r), 32'(q)};
      end
      default: begin
        if (y == 0) return {1'b1, m_hi, m_lo};
        return {1'b0, x % y, x / y};
      end
    endcase
  endfunction

  // Issue a mul/div, scramble operands while busy, time the done pulse.
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input string tag);
    logic [64:0] e;
    int lat, busy_cnt, exp_lat, exp_busy;
    bit seen;
    e = model(o, x, y);
    exp_q.push_back(e);
    if (o[1] && y == 0) begin exp_lat = 1; exp_busy = 0; end
    else if (o[1])      begin exp_lat = 34; exp_busy = 33; end
    else                begin exp_lat = MUL_LAT; exp_busy = MUL_BUSY; end
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    lat = 0; busy_cnt = 0; seen = 0;
    for (int c = 1; c <= 60 && !seen; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin seen = 1; lat = c; end
    end
    check({tag, " done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      e = exp_q.pop_front();
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
      check({tag, " hi_lo"}, {hi, lo}, e[63:0]);
      check({tag, " dbz"}, 64'(div_by_zero), 64'(e[64]));
      check({tag, " busy_at_done"}, 64'(busy), 64'd0);
      m_hi = e[63:32]; m_lo = e[31:0];
    end else begin
      void'(exp_q.pop_front());
    end
    @(posedge clk); #1;
  endtask

  // MTHI/MTLO/reserved: no done, optional coincident flush drops it.
  task automatic do_move(input logic [2:0] o, input logic [31:0] x, input bit with_flush,
                         input string tag);
    if (!with_flush) begin
      if (o == 3'd4) m_hi = x;
      else if (o == 3'd5) m_lo = x;
    end
    op = o; a = x; b = $urandom; start = 1'b1; flush = with_flush;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check({tag, " hi_lo"}, {hi, lo}, {m_hi, m_lo});
    check({tag, " no_done"}, 64'(done), 64'd0);
    check({tag, " no_busy"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int dones;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst dbz", 64'(div_by_zero), 64'd0);
    check("rst hi_lo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(3'd0, 32'hFFFF_FFFE, 32'd3, "mult_neg");
    check("mult_neg const", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    check("multu_max const", {m_hi, m_lo}, 64'hFFFF_FFFE_0000_0001);
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div_neg");
    check("div_neg const", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(3'd3, 32'd5, 32'd0, "divu_zero");
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_wrap");
    check("div_wrap const", {m_hi, m_lo}, 64'h0000_0000_8000_0000);
    do_move(3'd4, 32'h1234, 1'b0, "mthi");
    check("mthi const", 64'(hi), 64'h1234);
    do_move(3'd5, 32'hCAFE_F00D, 1'b1, "mtlo_flush");
    do_move(3'd6, 32'h5555_AAAA, 1'b0, "rsv6");

    // Flush mid-divide; a second start along the way must be ignored.
    op = 3'd3; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    op = 3'd1; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush busy", 64'(busy), 64'd0);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("flush no_done", 64'(dones), 64'd0);
    check("flush hi_lo", {hi, lo}, {m_hi, m_lo});
    @(posedge clk); #1;

    // Start and flush together from IDLE: dropped.
    op = 3'd2; a = 32'd100; b = 32'd3; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("start_flush busy", 64'(busy), 64'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      logic [2:0] ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 16));
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if (ro >= 3'd4) do_move(ro, ra, $urandom_range(0, 3) == 0, "rand_move");
      else            do_op(ro, ra, rb, "rand_op");
    end

    // Reset in the middle of a divide clears everything at once.
    op = 3'd2; a = 32'h1234_5678; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done_dbz", {62'd0, done, div_by_zero}, 64'd0);
    check("midrst hi_lo", {hi, lo}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    @(posedge clk); #1;
    do_op(3'd3, 32'd100, 32'd7, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
